fault_detect_ctrl: RTL and testbench

FAULT_DETECT_CTRL -- requirements
Module: fault_detect_ctrl

---
 rtl/fault_detect_ctrl.sv | 157 +++++++++++++++
 tb/tb_fault_detect_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fault_detect_ctrl.sv
// rtl/fault_detect_ctrl.sv - built-in self test sequencer for four full-adder cells
//
// Purpose: sweeps all eight operand combinations (lut_i = {a,b,cin}) into four
// isolated full-adder cells, holds each pattern SETTLE+1 cycles, then compares
// the cells' sum/carry against the expected values and pulses per-cell flags.
// Optional periodic re-test after each completed sweep.
//
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-low reset
//   start      single-cycle sweep request (honoured in IDLE and DONE)
//   auto_en    enables automatic re-test PERIOD cycles after DONE entry
//   fa_s/fa_c  sum/carry outputs of the cells under test
//   t_a/t_b/t_cin  registered per-cell test operands
//   test_mode  high while cells are isolated (APPLY/SETTLE_W/CAPTURE)
//   lut_i      current pattern index
//   sf/cf      per-cell sum/carry mismatch, one-cycle pulse after CAPTURE
//   busy       high outside IDLE and DONE
//   done       one-cycle pulse on DONE entry
//   fault_any  sticky OR of sf/cf since the last sweep start

module fault_detect_ctrl #(
  parameter int SETTLE = 2,
  parameter int PERIOD = 256
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       auto_en,
  input  logic [3:0] fa_s,
  input  logic [3:0] fa_c,
  output logic [3:0] t_a,
  output logic [3:0] t_b,
  output logic [3:0] t_cin,
  output logic       test_mode,
  output logic [2:0] lut_i,
  output logic [3:0] sf,
  output logic [3:0] cf,
  output logic       busy,
  output logic       done,
  output logic       fault_any
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APPLY    = 3'd1,
    SETTLE_W = 3'd2,
    CAPTURE  = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(PERIOD - 1);

  state_t      state;
  logic [3:0]  settle_cnt;
  logic [15:0] ival_cnt;

  logic       exp_sum;
  logic       exp_carry;
  logic [3:0] sf_next;
  logic [3:0] cf_next;
  logic [2:0] lut_next;
  logic       go;

  // Expected full-adder response for the pattern currently applied.
  assign exp_sum   = lut_i[2] ^ lut_i[1] ^ lut_i[0];
  assign exp_carry = (lut_i[2] & lut_i[1]) | (lut_i[2] & lut_i[0]) | (lut_i[1] & lut_i[0]);
  assign sf_next   = fa_s ^ {4{exp_sum}};
  assign cf_next   = fa_c ^ {4{exp_carry}};
  assign lut_next  = lut_i + 3'd1;

  // Sweep launch: explicit start from IDLE/DONE, or interval expiry in DONE.
  // start has priority simply because both lead to the same restart.
  assign go = ((state == IDLE) && start) ||
              ((state == DONE) && (start || (auto_en && (ival_cnt == PERIOD_LAST))));

  always_ff @(posedge clk) begin
    if (!clr) begin
      state      <= IDLE;
      settle_cnt <= '0;
      ival_cnt   <= '0;
      t_a        <= '0;
      t_b        <= '0;
      t_cin      <= '0;
      test_mode  <= 1'b0;
      lut_i      <= '0;
      sf         <= '0;
      cf         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault_any  <= 1'b0;
    end else begin
      // Pulse outputs default low; only CAPTURE and DONE entry raise them.
      sf   <= '0;
      cf   <= '0;
      done <= 1'b0;

      if (go) begin
        state     <= APPLY;
        lut_i     <= '0;
        t_a       <= '0;
        t_b       <= '0;
        t_cin     <= '0;
        test_mode <= 1'b1;
        busy      <= 1'b1;
        fault_any <= 1'b0;
        ival_cnt  <= '0;
      end else begin
        case (state)
          IDLE: ;

          APPLY: begin
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE_W;
          end

          SETTLE_W: begin
            if (settle_cnt == 4'd0) state <= CAPTURE;
            else settle_cnt <= settle_cnt - 4'd1;
          end

          CAPTURE: begin
            sf <= sf_next;
            cf <= cf_next;
            // Set together with the flags so fault_any rises in the same cycle.
            if ((|sf_next) || (|cf_next)) fault_any <= 1'b1;
            if (lut_i != 3'd7) begin
              lut_i <= lut_next;
              t_a   <= {4{lut_next[2]}};
              t_b   <= {4{lut_next[1]}};
              t_cin <= {4{lut_next[0]}};
              state <= APPLY;
            end else begin
              state     <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              test_mode <= 1'b0;
              t_a       <= '0;
              t_b       <= '0;
              t_cin     <= '0;
              ival_cnt  <= '0;
            end
          end

          DONE: begin
            if (!auto_en) ival_cnt <= '0;
            else ival_cnt <= ival_cnt + 16'd1;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fault_detect_ctrl.sv
// tb/tb_fault_detect_ctrl.sv - directed self-checking bench for fault_detect_ctrl

module tb_fault_detect_ctrl;

  logic       clk;
  logic       clr;
  logic       start;
  logic       auto_en;
  logic [3:0] fa_s;
  logic [3:0] fa_c;
  logic [3:0] t_a;
  logic [3:0] t_b;
  logic [3:0] t_cin;
  logic       test_mode;
  logic [2:0] lut_i;
  logic [3:0] sf;
  logic [3:0] cf;
  logic       busy;
  logic       done;
  logic       fault_any;

  logic [3:0] s_stuck0;
  logic [3:0] c_stuck1;

  int n_checks = 0;
  int n_fails  = 0;

  fault_detect_ctrl #(.SETTLE(2), .PERIOD(16)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .auto_en   (auto_en),
    .fa_s      (fa_s),
    .fa_c      (fa_c),
    .t_a       (t_a),
    .t_b       (t_b),
    .t_cin     (t_cin),
    .test_mode (test_mode),
    .lut_i     (lut_i),
    .sf        (sf),
    .cf        (cf),
    .busy      (busy),
    .done      (done),
    .fault_any (fault_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cells under test: ideal full adders with optional stuck-at faults.
  always_comb begin
    fa_s = (t_a ^ t_b ^ t_cin) & ~s_stuck0;
    fa_c = ((t_a & t_b) | (t_a & t_cin) | (t_b & t_cin)) | c_stuck1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_t_a"}, 32'(t_a), 32'h0);
    check_eq({pfx, "_t_b"}, 32'(t_b), 32'h0);
    check_eq({pfx, "_t_cin"}, 32'(t_cin), 32'h0);
    check_eq({pfx, "_lut_i"}, 32'(lut_i), 32'h0);
    check_eq({pfx, "_sf"}, 32'(sf), 32'h0);
    check_eq({pfx, "_cf"}, 32'(cf), 32'h0);
    check_eq({pfx, "_test_mode"}, 32'(test_mode), 32'h0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'h0);
    check_eq({pfx, "_done"}, 32'(done), 32'h0);
    check_eq({pfx, "_fault_any"}, 32'(fault_any), 32'h0);
  endtask

  // Called in the first APPLY cycle (n=0). With SETTLE=2 each pattern k
  // spans n=4k..4k+3 (APPLY, SETTLE_W x2, CAPTURE); its flags show at n=4k+4,
  // and DONE is entered at n=32. s_hits/c_hits mark patterns expected to miscompare.
  task automatic run_sweep(input string nm, input logic [7:0] s_hits, input logic [3:0] s_val,
                           input logic [7:0] c_hits, input logic [3:0] c_val,
                           input int poke, input logic exp_fault);
    logic [2:0] kb;
    logic [3:0] esf;
    logic [3:0] ecf;
    check_eq({nm, "_n0_test_mode"}, 32'(test_mode), 32'h1);
    check_eq({nm, "_n0_busy"}, 32'(busy), 32'h1);
    check_eq({nm, "_n0_fault_any"}, 32'(fault_any), 32'h0);
    for (int n = 0; n <= 32; n++) begin
      if (n > 0) begin
        start = (n == poke);
        step();
        start = 1'b0;
      end
      if ((n % 4 == 0) && (n < 32)) begin
        kb = 3'(n / 4);
        check_eq($sformatf("%s_lut_n%0d", nm, n), 32'(lut_i), 32'(kb));
        check_eq($sformatf("%s_ta_n%0d", nm, n), 32'(t_a), 32'({4{kb[2]}}));
        check_eq($sformatf("%s_tb_n%0d", nm, n), 32'(t_b), 32'({4{kb[1]}}));
        check_eq($sformatf("%s_tcin_n%0d", nm, n), 32'(t_cin), 32'({4{kb[0]}}));
      end
      esf = ((n % 4 == 0) && (n >= 4) && s_hits[n / 4 - 1]) ? s_val : 4'h0;
      ecf = ((n % 4 == 0) && (n >= 4) && c_hits[n / 4 - 1]) ? c_val : 4'h0;
      check_eq($sformatf("%s_sf_n%0d", nm, n), 32'(sf), 32'(esf));
      check_eq($sformatf("%s_cf_n%0d", nm, n), 32'(cf), 32'(ecf));
      check_eq($sformatf("%s_done_n%0d", nm, n), 32'(done), 32'(n == 32));
      check_eq($sformatf("%s_busy_n%0d", nm, n), 32'(busy), 32'(n != 32));
    end
    check_eq({nm, "_end_test_mode"}, 32'(test_mode), 32'h0);
    check_eq({nm, "_end_t_a"}, 32'(t_a), 32'h0);
    check_eq({nm, "_end_t_cin"}, 32'(t_cin), 32'h0);
    check_eq({nm, "_end_lut_i"}, 32'(lut_i), 32'h7);
    check_eq({nm, "_end_fault_any"}, 32'(fault_any), 32'(exp_fault));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    clr      = 1'b0;
    start    = 1'b1;
    auto_en  = 1'b0;
    s_stuck0 = 4'h0;
    c_stuck1 = 4'h0;

    // Reset with start held high: start must be ignored.
    repeat (3) step();
    check_reset_vals("reset");
    clr   = 1'b1;
    start = 1'b0;
    step();
    check_eq("idle_after_reset_busy", 32'(busy), 32'h0);
    check_eq("idle_after_reset_tm", 32'(test_mode), 32'h0);

    // Fault-free sweep; stray start mid-sweep must be ignored.
    pulse_start();
    run_sweep("clean", 8'h00, 4'h0, 8'h00, 4'h0, 10, 1'b0);

    // fa_s[2] stuck at 0: misses where expected sum is 1 (patterns 1,2,4,7).
    s_stuck0 = 4'b0100;
    pulse_start();
    run_sweep("sa0", 8'b1001_0110, 4'b0100, 8'h00, 4'h0, 0, 1'b1);

    // fa_c[0] stuck at 1: misses where expected carry is 0 (patterns 0,1,2,4).
    s_stuck0 = 4'h0;
    c_stuck1 = 4'b0001;
    pulse_start();
    run_sweep("ca1", 8'h00, 4'h0, 8'b0001_0111, 4'b0001, 0, 1'b1);

    // Auto re-test: APPLY re-entered 16 cycles after DONE entry.
    c_stuck1 = 4'h0;
    auto_en  = 1'b1;
    for (int m = 1; m <= 15; m++) begin
      step();
      check_eq($sformatf("auto_wait_busy_m%0d", m), 32'(busy), 32'h0);
      check_eq($sformatf("auto_wait_fault_m%0d", m), 32'(fault_any), 32'h1);
    end
    step();
    run_sweep("auto", 8'h00, 4'h0, 8'h00, 4'h0, 0, 1'b0);

    // Start during DONE restarts immediately.
    repeat (4) step();
    check_eq("done_wait_busy", 32'(busy), 32'h0);
    pulse_start();
    check_eq("start_in_done_tm", 32'(test_mode), 32'h1);
    check_eq("start_in_done_lut", 32'(lut_i), 32'h0);

    // Reset mid-sweep while pattern 5 is settling.
    repeat (21) step();
    check_eq("mid_lut_i", 32'(lut_i), 32'h5);
    check_eq("mid_tm", 32'(test_mode), 32'h1);
    check_eq("mid_ta", 32'(t_a), 32'hf);
    clr     = 1'b0;
    auto_en = 1'b0;
    step();
    check_reset_vals("midreset");
    clr = 1'b1;
    repeat (3) step();
    check_eq("post_reset_idle_busy", 32'(busy), 32'h0);
    pulse_start();
    run_sweep("after_rst", 8'h00, 4'h0, 8'h00, 4'h0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
